// File: rtl/lat_pkg.sv
// rtl/lat_pkg.sv - shared types and defaults for the latency measurement scheduler
//
// Contents:
//   LAT_CNT_W_DEF : default latency counter width
//   LAT_CH_W_MAX  : channel index width for the widest supported channel count (16)
//   lat_state_e   : scheduler FSM states
//   lat_res_t     : one measurement result (channel, latency, timeout flag)
package lat_pkg;

  localparam int LAT_CNT_W_DEF = 16;
  localparam int LAT_CH_W_MAX  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    REPORT = 2'd2
  } lat_state_e;

  typedef struct packed {
    logic [LAT_CH_W_MAX-1:0]  ch;
    logic [LAT_CNT_W_DEF-1:0] lat;
    logic                     to;
  } lat_res_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Picks the first requesting channel searching upward from last+1,
// wrapping from N-1 back to 0. The previous winner is searched last.
//
// Ports:
//   req     in  N  : request vector
//   last    in  IW : index of the previous winner
//   gnt     out N  : one-hot grant (all zero when req is zero)
//   gnt_idx out IW : index of the granted channel (0 when req is zero)
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  int unsigned   j;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    idx     = '0;
    // i = N revisits 'last' itself so a lone requester on the previous
    // winner is still served.
    for (int i = 1; i <= N; i++) begin
      j   = (int'(last) + i) % N;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lat_meas_sched.sv
// rtl/lat_meas_sched.sv - shared-counter latency measurement scheduler
//
// Channels request a measurement with a start pulse. One shared counter
// serves pending channels round-robin, timing each from its grant to the
// next rising edge of its sig_i bit, and reports through a valid/ready port.
//
// Optional feature macro: LAT_TIMEOUT_EN (abort a measurement at TIMEOUT
// cycles and report res_to_o = 1). Without it MEAS waits forever, the
// counter saturates, and res_to_o is constant 0.
//
// Ports:
//   clk          in  1         : clock, rising edge
//   rst_n        in  1         : asynchronous active-low reset
//   start_i      in  N         : per-channel start pulses (set pending bits)
//   sig_i        in  N         : signals under measurement (clk-synchronous)
//   res_ready_i  in  1         : result consumer ready
//   res_valid_o  out 1         : result valid (state REPORT)
//   res_ch_o     out clog2(N)  : result channel
//   res_lat_o    out CNT_W     : measured latency in cycles
//   res_to_o     out 1         : result ended by timeout
//   busy_o       out 1         : FSM not IDLE
//   pend_o       out N         : pending bits
module lat_meas_sched
  import lat_pkg::*;
#(
  parameter  int N       = 2,
  parameter  int CNT_W   = LAT_CNT_W_DEF,
  parameter  int TIMEOUT = 1000,
  localparam int CW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     start_i,
  input  logic [N-1:0]     sig_i,
  input  logic             res_ready_i,
  output logic             res_valid_o,
  output logic [CW-1:0]    res_ch_o,
  output logic [CNT_W-1:0] res_lat_o,
  output logic             res_to_o,
  output logic             busy_o,
  output logic [N-1:0]     pend_o
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("lat_meas_sched: N must be within 2..16");
  end

  if (TIMEOUT < 0) begin : g_bad_timeout_sign
    $error("lat_meas_sched: TIMEOUT must not be negative");
  end

`ifdef LAT_TIMEOUT_EN
  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout_range
    $error("lat_meas_sched: TIMEOUT must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
`endif

  lat_state_e       state_q, state_d;
  logic [N-1:0]     pend_q,  pend_d;
  logic [CW-1:0]    ch_q,    ch_d;
  logic [CW-1:0]    last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             prev_q,  prev_d;
  logic [CNT_W-1:0] lat_q,   lat_d;
  logic             to_q,    to_d;

  logic [N-1:0]     arb_gnt;
  logic [CW-1:0]    arb_idx;
  logic [N-1:0]     gnt_oh;
  logic             sig_ch;
  logic             rise;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req     (pend_q),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    lat_d   = lat_q;
    to_d    = to_q;
    gnt_oh  = '0;
    sig_ch  = sig_i[ch_q];
    rise    = sig_ch & ~prev_q;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          gnt_oh  = arb_gnt;
          ch_d    = arb_idx;
          last_d  = arb_idx;
          cnt_d   = CNT_W'(1);
          // Sampling the level at grant means a signal already high must
          // fall and rise again before it counts as an edge.
          prev_d  = sig_i[arb_idx];
          state_d = MEAS;
        end
      end

      MEAS: begin
        prev_d = sig_ch;
        if (rise) begin
          lat_d   = cnt_q;
          to_d    = 1'b0;
          state_d = REPORT;
        end
`ifdef LAT_TIMEOUT_EN
        else if (cnt_q == TO_VAL) begin
          lat_d   = TO_VAL;
          to_d    = 1'b1;
          state_d = REPORT;
        end
`endif
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      REPORT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A start landing on its own grant cycle re-arms the channel, and a start
    // for the channel under measurement queues a second measurement.
    pend_d = (pend_q & ~gnt_oh) | start_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ch_q    <= '0;
      last_q  <= CW'(N - 1);
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      lat_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
    end
  end

  assign res_valid_o = (state_q == REPORT);
  assign busy_o      = (state_q != IDLE);
  assign res_ch_o    = ch_q;
  assign res_lat_o   = lat_q;
  assign res_to_o    = to_q;
  assign pend_o      = pend_q;

endmodule
